dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder for the pipeline's load/store request interface. It is the slave end of the memory stage's access path. It accepts one request at a time over a valid/ready handshake and models configurable wait-state latency. It performs byte-lane writes into an internal word array and returns read data or an error over a valid/ready response channel.

Parameters:
XLEN, 32, data/address width in bits (32 or 64); one word = XLEN/8 bytes.
MEMORY_CAPACITY, 256, number of XLEN-bit words in the array.
WAIT_CYCLES, 2, extra cycles between request acceptance and response (0 allowed).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  XLEN  byte address.
req_wdata  in  XLEN  store data.
req_be  in  XLEN/8  store byte enables; bit i enables byte lane i. Ignored on loads.
rsp_valid  out  1  response present.
rsp_ready  in  1  requester accepts the response.
rsp_rdata  out  XLEN  load data; 0 for stores and errors.
rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - While reset is high, and after it: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - req_ready=0 in any cycle where reset=1.
  - Array contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) & ~reset. It is a function of registered state only, never of req_valid.
- IDLE:
  - On req_valid & req_ready, capture we/addr/wdata/be.
  - Compute err = (addr[log2(XLEN/8)-1:0] != 0) | ((addr >> log2(XLEN/8)) >= MEMORY_CAPACITY).
  - If WAIT_CYCLES==0, go to RESP; else go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: counter decrements each cycle. When counter==0, go to RESP on the next edge.
- Commit (entry edge into RESP):
  - Store without error: each enabled byte lane of the addressed word is overwritten with the corresponding wdata byte. be=0 is a legal no-op store.
  - Load without error: rsp_rdata = word at the addressed index, sampled after any same-edge write. There is no concurrent write, so this is simply the current word.
  - Error: no array change; rsp_rdata=0; rsp_err=1.
  - Non-error responses drive rsp_err=0. Stores drive rsp_rdata=0.
- Latency: a request accepted at edge T gives rsp_valid=1 from edge T+1+WAIT_CYCLES.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready.
  - On that handshake edge: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- No overlap: req_ready=0 throughout WAIT and RESP. The minimum request-to-next-accept period is 2+WAIT_CYCLES cycles when rsp_ready is held high.
- req_valid is ignored outside IDLE; request inputs are sampled only at acceptance.
- Reset mid-operation:
  - In WAIT, the pending transaction is dropped and its store never commits.
  - In RESP, the store has already committed and stays; the response is discarded.
- Array index = addr >> log2(XLEN/8). It is used only when range-checked.
- Counter width = max(1, clog2(WAIT_CYCLES+1)).

Test Plan:
- Reset, then WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, be=0xF accepted at edge T -> rsp_valid at T+3, rsp_err=0, rsp_rdata=0. Load 0x10 -> rsp_rdata=0xDEADBEEF.
- Partial store: store 0x10, wdata=0x00AA0000, be=0x4, then load 0x10 -> 0xDEAABEEF. Store with be=0x0 -> word unchanged.
- Errors (MEMORY_CAPACITY=256):
  - Load 0x12 -> rsp_err=1, rsp_rdata=0.
  - Store 0x400 -> rsp_err=1 and a subsequent load of 0x0 is unchanged.
  - Load 0x3FC -> rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, and a second req_valid is not accepted. Raise rsp_ready -> IDLE next edge, req_ready=1.
- WAIT_CYCLES=0 build: back-to-back loads with rsp_ready=1 -> rsp_valid one edge after accept, accepts every 2 cycles.
- Assert reset one cycle after accepting a store to 0x20 (in WAIT) -> rsp_valid never rises, req_ready=0 during reset then 1, and a later load of 0x20 returns the old contents.

Source files
------------

// File: rtl/dmem_if.sv
// =============================================================================
// Module : dmem_if
// Desc   : Load/store request and response channels between the memory stage
//          and its data-memory responder.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

interface dmem_if #(
    parameter int XLEN = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [XLEN-1:0]      req_addr;
    logic [XLEN-1:0]      req_wdata;
    logic [XLEN/8-1:0]    req_be;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [XLEN-1:0]      rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// =============================================================================
// Module : dmem_responder
// Desc   : Single-outstanding data-memory responder with byte-lane stores,
//          programmable wait states and a registered valid/ready response.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module dmem_responder #(
    parameter int XLEN            = 32,
    parameter int MEMORY_CAPACITY = 256,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic    clk,
    input  logic    reset,
    dmem_if.slave   bus
);

    localparam int c_NBYTES = XLEN / 8;
    localparam int c_OFFW   = $clog2(c_NBYTES);
    localparam int c_IDXW   = (MEMORY_CAPACITY > 1) ? $clog2(MEMORY_CAPACITY) : 1;
    localparam int c_CNTW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam bit c_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [XLEN-1:0]   c_CAP      = XLEN'(MEMORY_CAPACITY);
    localparam logic [c_CNTW-1:0] c_CNT_INIT = (WAIT_CYCLES > 0) ? c_CNTW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_CNTW-1:0]      r_cnt;
    logic                   r_we;
    logic                   r_err;
    logic [c_IDXW-1:0]      r_idx;
    logic [XLEN-1:0]        r_wdata;
    logic [c_NBYTES-1:0]    r_be;
    logic                   r_rsp_valid;
    logic                   r_rsp_err;
    logic [XLEN-1:0]        r_rsp_rdata;
    logic [XLEN-1:0]        r_mem [MEMORY_CAPACITY];

    logic                   w_req_ready;
    logic                   w_accept;
    logic [XLEN-1:0]        w_req_idx_full;
    logic                   w_req_err;
    logic                   w_commit;
    logic                   w_c_we;
    logic                   w_c_err;
    logic [c_IDXW-1:0]      w_c_idx;
    logic [XLEN-1:0]        w_c_wdata;
    logic [c_NBYTES-1:0]    w_c_be;
    logic [XLEN-1:0]        w_c_rdata;

    assign w_req_ready    = (r_state == S_IDLE) & ~reset;
    assign w_accept       = bus.req_valid & w_req_ready;
    assign w_req_idx_full = bus.req_addr >> c_OFFW;
    assign w_req_err      = (|bus.req_addr[c_OFFW-1:0]) | (w_req_idx_full >= c_CAP);

    // With zero wait states the commit edge is the accept edge, so the live
    // request fields are used; otherwise the captured copy is.
    assign w_commit  = (c_ZERO_WAIT & w_accept)
                     | (~reset & (r_state == S_WAIT) & (r_cnt == '0));
    assign w_c_we    = (r_state == S_IDLE) ? bus.req_we                     : r_we;
    assign w_c_err   = (r_state == S_IDLE) ? w_req_err                      : r_err;
    assign w_c_idx   = (r_state == S_IDLE) ? w_req_idx_full[c_IDXW-1:0]    : r_idx;
    assign w_c_wdata = (r_state == S_IDLE) ? bus.req_wdata                  : r_wdata;
    assign w_c_be    = (r_state == S_IDLE) ? bus.req_be                     : r_be;
    assign w_c_rdata = (w_c_we | w_c_err) ? '0 : r_mem[w_c_idx];

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (w_commit && w_c_we && !w_c_err) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (w_c_be[i]) begin
                    r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_err   <= w_req_err;
                        r_idx   <= w_req_idx_full[c_IDXW-1:0];
                        r_wdata <= bus.req_wdata;
                        r_be    <= bus.req_be;
                        if (c_ZERO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_CNTW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_c_err;
                r_rsp_rdata <= w_c_rdata;
            end
        end
    end

endmodule

`default_nettype wire
